// File: rtl/seg595_rx.sv
// Receiver for a serial 74HC595-style chain: synchronizes sclk/data/latch, shifts on sclk edges, commits frames on latch edges.
// Latency: word_valid_o rises SYNC_STAGES+1 clk_i edges after latch_i is first sampled high; the digit bytes update in the same cycle.
// Backpressure: none; the serial source must respect the input timing contract. Optional SEG595_RX_BITCHECK_EN rejects short or long frames.
module seg595_rx #(
    parameter int NUM_ICS     = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sclk_i,
    input  logic                 data_i,
    input  logic                 latch_i,
    output logic [8*NUM_ICS-1:0] word_o,
    output logic                 word_valid_o,
    output logic [31:0]          digit_seg_o,
    output logic                 err_o,
    output logic [4:0]           bit_count_o
);

    localparam int W = 8 * NUM_ICS;

    // Synchronizer chains; the data chain has the same depth as sclk so both arrive aligned.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic                   sclk_hist_q;
    logic                   latch_hist_q;

    logic [W-1:0]  sr_q, sr_d;
    logic [W-1:0]  word_q, word_d;
    logic          valid_q, valid_d;
    logic [31:0]   seg_q, seg_d;
    logic [4:0]    cnt_q, cnt_d;

    logic          sclk_edge;
    logic          latch_edge;
    logic [W-1:0]  sr_shift;
    logic [4:0]    cnt_inc;
    logic          commit_ok;
    logic [3:0]    mask;

    assign sclk_edge  = sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
    assign latch_edge = latch_sync_q[SYNC_STAGES-1] & ~latch_hist_q;

    // Shift happens before commit so a same-cycle final bit lands in the committed word.
    assign sr_shift = sclk_edge ? {sr_q[W-2:0], data_sync_q[SYNC_STAGES-1]} : sr_q;
    assign cnt_inc  = (sclk_edge && (cnt_q != 5'd31)) ? (cnt_q + 5'd1) : cnt_q;
    assign mask     = sr_shift[3:0];

`ifdef SEG595_RX_BITCHECK_EN
    localparam logic [31:0] W_U = W;
    logic err_q, err_d;
    assign commit_ok = ({27'd0, cnt_inc} == W_U);
    assign err_o     = err_q;
`else
    assign commit_ok = 1'b1;
    assign err_o     = 1'b0;
`endif

    // Next-state for shift register, counter, committed word and digit bytes.
    always_comb begin
        sr_d    = sr_shift;
        cnt_d   = cnt_inc;
        word_d  = word_q;
        valid_d = 1'b0;
        seg_d   = seg_q;
`ifdef SEG595_RX_BITCHECK_EN
        err_d   = err_q;
`endif
        if (latch_edge) begin
            cnt_d = 5'd0;
            if (commit_ok) begin
                word_d  = sr_shift;
                valid_d = 1'b1;
                // Only a single selected digit is updated; zero or several mask bits leave the display alone.
                case (mask)
                    4'b0001: seg_d[7:0]   = sr_shift[W-1 -: 8];
                    4'b0010: seg_d[15:8]  = sr_shift[W-1 -: 8];
                    4'b0100: seg_d[23:16] = sr_shift[W-1 -: 8];
                    4'b1000: seg_d[31:24] = sr_shift[W-1 -: 8];
                    default: seg_d        = seg_q;
                endcase
            end
`ifdef SEG595_RX_BITCHECK_EN
            else begin
                err_d = 1'b1;
            end
`endif
        end
    end

    // All state, including synchronizers, clears on reset so no edge is seen right after release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync_q  <= '0;
            data_sync_q  <= '0;
            latch_sync_q <= '0;
            sclk_hist_q  <= 1'b0;
            latch_hist_q <= 1'b0;
            sr_q         <= '0;
            word_q       <= '0;
            valid_q      <= 1'b0;
            seg_q        <= '0;
            cnt_q        <= '0;
`ifdef SEG595_RX_BITCHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], data_i};
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], latch_i};
            sclk_hist_q  <= sclk_sync_q[SYNC_STAGES-1];
            latch_hist_q <= latch_sync_q[SYNC_STAGES-1];
            sr_q         <= sr_d;
            word_q       <= word_d;
            valid_q      <= valid_d;
            seg_q        <= seg_d;
            cnt_q        <= cnt_d;
`ifdef SEG595_RX_BITCHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign digit_seg_o  = seg_q;
    assign bit_count_o  = cnt_q;

endmodule

// File: doc/seg595_rx.md
SEG595_RX -- requirements
Module: seg595_rx

Interface
REQ-001 Parameter NUM_ICS, default 2: number of chained 74HC595 stages emulated; frame width W = 8*NUM_ICS; only the digit-capture behaviour below is defined for W = 16.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flops per serial input, minimum 2.
REQ-003 clk_i  input  1: the one block clock, rising-edge; all state in this domain.
REQ-004 rst_i  input  1: asynchronous, active-high reset.
REQ-005 sclk_i  input  1: serial shift clock, asynchronous to clk_i.
REQ-006 data_i  input  1: serial data, sampled on sclk_i rising edge.
REQ-007 latch_i  input  1: latch enable; rising edge commits a frame.
REQ-008 word_o  output  W: last committed frame.
REQ-009 word_valid_o  output  1: one-cycle pulse when word_o updates.
REQ-010 digit_seg_o  output  32: four 8-bit segment bytes, digit n at bits [8n+7:8n].
REQ-011 err_o  output  1: sticky frame-error flag.
REQ-012 bit_count_o  output  5: sclk edges since last latch edge, saturating at 31.

Function
REQ-013 Each serial input passes through SYNC_STAGES flops plus one history flop; an edge = synchronized value 1 with history value 0.
REQ-014 On an sclk rising edge, shift register sr shifts left and takes synchronized data_i into bit 0; the first bit shifted ends at MSB.
REQ-015 data_i is taken from its synchronizer stage aligned with sclk_i; no extra skew between the two paths.
REQ-016 Each sclk edge increments bit_count_o, which holds at 31 and never wraps.
REQ-017 On a latch rising edge, the commit takes sr including any bit shifted in the same cycle (shift before commit).
REQ-018 A commit loads word_o and pulses word_valid_o high the next cycle, then clears bit_count_o to 0; an sclk edge in the commit cycle counts as 1.
REQ-019 Latency: word_valid_o is high in the cycle after the (SYNC_STAGES+1)th clk_i edge that samples latch_i high.
REQ-020 Digit capture on commit (W=16): digit mask = word[3:0]; if exactly one bit n is set, digit_seg_o byte n <= word[15:8]; zero or multiple bits set leaves digit_seg_o unchanged.
REQ-021 Bits above W and word[7:4] are ignored by digit capture.
REQ-022 More than W sclk edges before a latch: oldest bits are shifted out, matching a physical 595 chain.
REQ-023 Latch with no preceding sclk edges recommits the unchanged sr.
REQ-024 Input timing contract: sclk_i and latch_i high and low phases each >= SYNC_STAGES+1 clk_i cycles, and data_i stable across that window; behaviour is undefined outside it.

Reset
REQ-025 While rst_i is high: synchronizers, history flops, sr, word_o, digit_seg_o, bit_count_o = 0; word_valid_o = 0; err_o = 0; held until release.
REQ-026 Reset mid-frame discards partial bits; the first frame after release starts empty, with no spurious edge from zero-reset history flops.

Configuration
REQ-027 Macro SEG595_RX_BITCHECK_EN.
- Defined: a commit with bit_count != W (after counting a same-cycle sclk edge) sets err_o, leaves word_o and digit_seg_o unchanged, suppresses word_valid_o, and still clears bit_count_o.
- Not defined: every commit is accepted; err_o is tied to 0.

Verification
REQ-028 Shift 16 bits 0x3F01, MSB first, then latch -> word_o = 0x3F01, one word_valid_o pulse, digit_seg_o[7:0] = 0x3F, bit_count_o = 0.
REQ-029 Four frames 0x0601, 0x5B02, 0x4F04, 0x6608 -> digit_seg_o = 0x664F5B06.
REQ-030 Frame 0xFF03 (two digit bits) after REQ-029 -> word_o = 0xFF03, digit_seg_o unchanged at 0x664F5B06.
REQ-031 20 sclk edges with bits 0xA, then 0x1234, then latch -> word_o = 0x1234; with SEG595_RX_BITCHECK_EN, err_o = 1 and word_o keeps its previous value.
REQ-032 Assert rst_i after 9 bits, release, send 0x7F02 + latch -> digit_seg_o = 0x00007F00, err_o = 0.
REQ-033 Last sclk edge and latch edge in the same clk_i cycle -> the committed word includes the final bit, and no error is raised with SEG595_RX_BITCHECK_EN.
